// File: rtl/ps2_keydecode.sv
// ---------------------------------------------------------------------------
// ps2_keydecode
//   Converts PS/2 set-2 scancode bytes into ASCII bytes. Tracks the E0
//   (extended) and F0 (break) prefixes, the shift/ctrl/caps-lock modifiers,
//   and queues translated bytes in a small output FIFO.
//
// Optional build macro: KEYDEC_EXTENDED_EN
//   When defined, extended makes for the cursor/home/end keys produce codes
//   80..85. When undefined, every extended make other than ctrl is dropped.
//
// Ports:
//   i_clk48       system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_sym_data    scancode byte from the PS/2 receiver
//   i_sym_valid   i_sym_data is valid
//   o_sym_ready   decoder accepts a byte this cycle (FIFO not full)
//   o_key_data    ASCII byte at the FIFO head
//   o_key_valid   o_key_data is valid
//   i_key_ready   consumer takes o_key_data this cycle
//   o_caps_state  current caps-lock toggle
// ---------------------------------------------------------------------------
module ps2_keydecode #(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic       i_clk48,
  input  logic       i_rst_n,
  input  logic [7:0] i_sym_data,
  input  logic       i_sym_valid,
  output logic       o_sym_ready,
  output logic [7:0] o_key_data,
  output logic       o_key_valid,
  input  logic       i_key_ready,
  output logic       o_caps_state
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;

  localparam logic [FIFO_AW:0] LP_FULL = FIFO_DEPTH[FIFO_AW:0];

  state_t             r_state, w_state_next;
  logic               r_sym_ready;
  logic               r_lshift, r_rshift, r_ctrl, r_caps;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_count, w_count_next;

  logic       w_accept, w_final, w_ext, w_brk, w_push, w_pop;
  logic       w_upper, w_shift, w_is_letter;
  logic [4:0] w_letter_idx;
  logic       w_xlat_valid;
  logic [7:0] w_xlat_data;

  assign w_accept = i_sym_valid && r_sym_ready;
  assign w_pop    = (r_count != '0) && i_key_ready;
  assign w_push   = w_final && !w_brk && w_xlat_valid;

  // State register
  always_ff @(posedge i_clk48 or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic: prefixes only advance from IDLE/EXT; anything else ends the sequence
  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (i_sym_data == 8'hE0)      w_state_next = ST_EXT;
          else if (i_sym_data == 8'hF0) w_state_next = ST_BRK;
          else                          w_state_next = ST_IDLE;
        end
        ST_EXT:  w_state_next = (i_sym_data == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Output logic: flags the accepted byte as the final code byte of a sequence
  always_comb begin
    w_final = 1'b0;
    w_ext   = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
    w_brk   = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
    if (w_accept) begin
      case (r_state)
        ST_IDLE: w_final = (i_sym_data != 8'hE0) && (i_sym_data != 8'hF0);
        ST_EXT:  w_final = (i_sym_data != 8'hF0);
        default: w_final = 1'b1;
      endcase
    end
  end

  assign w_shift = r_lshift | r_rshift;
  assign w_upper = w_shift ^ r_caps;

  // Scancode to ASCII; letters go through an index so case and ctrl are computed once
  always_comb begin
    w_xlat_valid = 1'b0;
    w_xlat_data  = 8'h00;
    w_is_letter  = 1'b0;
    w_letter_idx = 5'd0;
    if (!w_ext) begin
      w_xlat_valid = 1'b1;
      case (i_sym_data)
        8'h1C: begin w_is_letter = 1'b1; w_letter_idx = 5'd0;  end
        8'h32: begin w_is_letter = 1'b1; w_letter_idx = 5'd1;  end
        8'h21: begin w_is_letter = 1'b1; w_letter_idx = 5'd2;  end
        8'h23: begin w_is_letter = 1'b1; w_letter_idx = 5'd3;  end
        8'h24: begin w_is_letter = 1'b1; w_letter_idx = 5'd4;  end
        8'h2B: begin w_is_letter = 1'b1; w_letter_idx = 5'd5;  end
        8'h34: begin w_is_letter = 1'b1; w_letter_idx = 5'd6;  end
        8'h33: begin w_is_letter = 1'b1; w_letter_idx = 5'd7;  end
        8'h43: begin w_is_letter = 1'b1; w_letter_idx = 5'd8;  end
        8'h3B: begin w_is_letter = 1'b1; w_letter_idx = 5'd9;  end
        8'h42: begin w_is_letter = 1'b1; w_letter_idx = 5'd10; end
        8'h4B: begin w_is_letter = 1'b1; w_letter_idx = 5'd11; end
        8'h3A: begin w_is_letter = 1'b1; w_letter_idx = 5'd12; end
        8'h31: begin w_is_letter = 1'b1; w_letter_idx = 5'd13; end
        8'h44: begin w_is_letter = 1'b1; w_letter_idx = 5'd14; end
        8'h4D: begin w_is_letter = 1'b1; w_letter_idx = 5'd15; end
        8'h15: begin w_is_letter = 1'b1; w_letter_idx = 5'd16; end
        8'h2D: begin w_is_letter = 1'b1; w_letter_idx = 5'd17; end
        8'h1B: begin w_is_letter = 1'b1; w_letter_idx = 5'd18; end
        8'h2C: begin w_is_letter = 1'b1; w_letter_idx = 5'd19; end
        8'h3C: begin w_is_letter = 1'b1; w_letter_idx = 5'd20; end
        8'h2A: begin w_is_letter = 1'b1; w_letter_idx = 5'd21; end
        8'h1D: begin w_is_letter = 1'b1; w_letter_idx = 5'd22; end
        8'h22: begin w_is_letter = 1'b1; w_letter_idx = 5'd23; end
        8'h35: begin w_is_letter = 1'b1; w_letter_idx = 5'd24; end
        8'h1A: begin w_is_letter = 1'b1; w_letter_idx = 5'd25; end
        8'h45: w_xlat_data = w_shift ? 8'h29 : 8'h30;
        8'h16: w_xlat_data = w_shift ? 8'h21 : 8'h31;
        8'h1E: w_xlat_data = w_shift ? 8'h40 : 8'h32;
        8'h26: w_xlat_data = w_shift ? 8'h23 : 8'h33;
        8'h25: w_xlat_data = w_shift ? 8'h24 : 8'h34;
        8'h2E: w_xlat_data = w_shift ? 8'h25 : 8'h35;
        8'h36: w_xlat_data = w_shift ? 8'h5E : 8'h36;
        8'h3D: w_xlat_data = w_shift ? 8'h26 : 8'h37;
        8'h3E: w_xlat_data = w_shift ? 8'h2A : 8'h38;
        8'h46: w_xlat_data = w_shift ? 8'h28 : 8'h39;
        8'h4E: w_xlat_data = w_shift ? 8'h5F : 8'h2D;
        8'h55: w_xlat_data = w_shift ? 8'h2B : 8'h3D;
        8'h29: w_xlat_data = 8'h20;
        8'h5A: w_xlat_data = 8'h0D;
        8'h66: w_xlat_data = 8'h08;
        8'h0D: w_xlat_data = 8'h09;
        8'h76: w_xlat_data = 8'h1B;
        default: w_xlat_valid = 1'b0;
      endcase
      // Ctrl maps a letter to its control code: uppercase & 0x1F == index + 1
      if (w_is_letter) begin
        if (r_ctrl)       w_xlat_data = {3'b000, w_letter_idx} + 8'd1;
        else if (w_upper) w_xlat_data = 8'h41 + {3'b000, w_letter_idx};
        else              w_xlat_data = 8'h61 + {3'b000, w_letter_idx};
      end
    end else begin
`ifdef KEYDEC_EXTENDED_EN
      w_xlat_valid = 1'b1;
      case (i_sym_data)
        8'h75:   w_xlat_data = 8'h80;
        8'h72:   w_xlat_data = 8'h81;
        8'h6B:   w_xlat_data = 8'h82;
        8'h74:   w_xlat_data = 8'h83;
        8'h6C:   w_xlat_data = 8'h84;
        8'h69:   w_xlat_data = 8'h85;
        default: w_xlat_valid = 1'b0;
      endcase
`else
      w_xlat_valid = 1'b0;
`endif
    end
  end

  // Modifier tracking; modifier codes have no translation so they never push
  always_ff @(posedge i_clk48 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_ctrl   <= 1'b0;
      r_caps   <= 1'b0;
    end else if (w_final) begin
      if (!w_ext && i_sym_data == 8'h12) r_lshift <= !w_brk;
      if (!w_ext && i_sym_data == 8'h59) r_rshift <= !w_brk;
      if (i_sym_data == 8'h14)           r_ctrl   <= !w_brk;
      if (!w_ext && !w_brk && i_sym_data == 8'h58) r_caps <= !r_caps;
    end
  end

  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Output FIFO; ready is registered from the updated count so it tracks "not full"
  always_ff @(posedge i_clk48 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_sym_ready <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_xlat_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count     <= w_count_next;
      r_sym_ready <= (w_count_next != LP_FULL);
    end
  end

  assign o_sym_ready  = r_sym_ready;
  assign o_key_valid  = (r_count != '0);
  assign o_key_data   = r_mem[r_rd_ptr];
  assign o_caps_state = r_caps;

endmodule

// File: tb/tb_ps2_keydecode.sv
// ---------------------------------------------------------------------------
// tb_ps2_keydecode
//   Self-checking bench for ps2_keydecode. Each scenario task pushes the
//   ASCII bytes it expects onto a queue; a monitor pops and compares every
//   byte the decoder hands over.
// ---------------------------------------------------------------------------
module tb_ps2_keydecode;

  logic       clk48 = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sym_data = 8'h00;
  logic       sym_valid = 1'b0;
  logic       sym_ready;
  logic [7:0] key_data;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       caps_state;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [7:0] exp_q[$];

  ps2_keydecode #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
    .i_clk48     (clk48),
    .i_rst_n     (rst_n),
    .i_sym_data  (sym_data),
    .i_sym_valid (sym_valid),
    .o_sym_ready (sym_ready),
    .o_key_data  (key_data),
    .o_key_valid (key_valid),
    .i_key_ready (key_ready),
    .o_caps_state(caps_state)
  );

  always #5 clk48 = ~clk48;

  // Scoreboard monitor: the transfer happens on the coming rising edge
  always @(negedge clk48) begin
    if (rst_n && key_valid && key_ready) begin
      n_compared++;
      if (exp_q.size() == 0) begin
        n_mismatched++;
        $display("[TB] FAIL unexpected_output: got %02h, none expected", key_data);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        if (key_data !== e) begin
          n_mismatched++;
          $display("[TB] FAIL key_data: got %02h, expected %02h", key_data, e);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk48);
    sym_data  = b;
    sym_valid = 1'b1;
    while (!sym_ready && n < 200) begin
      @(negedge clk48);
      n++;
    end
    if (n >= 200) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL send_timeout: byte %02h not accepted, sym_ready=%0b", b, sym_ready);
    end
    @(posedge clk48);
    #1;
    sym_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || key_valid) && n < 200) begin
      @(posedge clk48);
      #1;
      n++;
    end
    n_compared++;
    if (exp_q.size() != 0 || key_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL drain: %0d expected bytes left, key_valid=%0b", exp_q.size(), key_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk48);
    #1;
    n_compared++;
    if ({sym_ready, key_valid, key_data, caps_state} !== 11'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: got rdy=%0b vld=%0b data=%02h caps=%0b, expected all 0",
               sym_ready, key_valid, key_data, caps_state);
    end
    @(negedge clk48);
    rst_n = 1'b1;
    @(posedge clk48);
    #1;
    n_compared++;
    if (sym_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL ready_after_reset: got %0b, expected 1", sym_ready);
    end
  endtask

  task automatic test_make_break();
    key_ready = 1'b1;
    exp_q.push_back(8'h61);
    send_byte(8'h1C);
    n_compared++;
    if (key_valid !== 1'b1 || key_data !== 8'h61) begin
      n_mismatched++;
      $display("[TB] FAIL latency: vld=%0b data=%02h, expected 1/61", key_valid, key_data);
    end
    @(posedge clk48);
    #1;
    n_compared++;
    if (key_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL single_pulse: key_valid=%0b, expected 0", key_valid);
    end
    send_byte(8'hF0);
    send_byte(8'h1C);
    wait_drain();
  endtask

  task automatic test_modifiers();
    key_ready = 1'b1;
    send_byte(8'h12); exp_q.push_back(8'h41); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h12);
    exp_q.push_back(8'h61); send_byte(8'h1C);
    send_byte(8'h58);
    n_compared++;
    if (caps_state !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL caps_on: got %0b, expected 1", caps_state);
    end
    exp_q.push_back(8'h41); send_byte(8'h1C);
    send_byte(8'h12); exp_q.push_back(8'h61); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h12);
    send_byte(8'hF0); send_byte(8'h58);
    n_compared++;
    if (caps_state !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL caps_break_ignored: got %0b, expected 1", caps_state);
    end
    send_byte(8'h58);
    n_compared++;
    if (caps_state !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL caps_off: got %0b, expected 0", caps_state);
    end
    send_byte(8'h14); exp_q.push_back(8'h03); send_byte(8'h21);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
    exp_q.push_back(8'h63); send_byte(8'h21);
    send_byte(8'hE0); send_byte(8'h14); exp_q.push_back(8'h1A); send_byte(8'h1A);
    send_byte(8'hF0); send_byte(8'h14);
    send_byte(8'h59); exp_q.push_back(8'h5A); send_byte(8'h1A);
    exp_q.push_back(8'h21); send_byte(8'h16);
    exp_q.push_back(8'h29); send_byte(8'h45);
    exp_q.push_back(8'h5F); send_byte(8'h4E);
    exp_q.push_back(8'h2B); send_byte(8'h55);
    send_byte(8'hF0); send_byte(8'h59);
    exp_q.push_back(8'h2D); send_byte(8'h4E);
    exp_q.push_back(8'h39); send_byte(8'h46);
    exp_q.push_back(8'h20); send_byte(8'h29);
    exp_q.push_back(8'h0D); send_byte(8'h5A);
    exp_q.push_back(8'h08); send_byte(8'h66);
    exp_q.push_back(8'h09); send_byte(8'h0D);
    exp_q.push_back(8'h1B); send_byte(8'h76);
    send_byte(8'hAA); send_byte(8'hFA); send_byte(8'hFE); send_byte(8'hEE);
    send_byte(8'hE0); send_byte(8'hE0);
    send_byte(8'hF0); send_byte(8'hF0);
    exp_q.push_back(8'h62); send_byte(8'h32);
    wait_drain();
  endtask

  task automatic test_backpressure();
    int n = 0;
    @(posedge clk48); #1;
    key_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h61);
      send_byte(8'h1C);
    end
    n_compared++;
    if (sym_ready !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL full_ready: got %0b, expected 0", sym_ready);
    end
    exp_q.push_back(8'h61);
    @(negedge clk48);
    sym_data  = 8'h1C;
    sym_valid = 1'b1;
    repeat (3) @(posedge clk48);
    #1;
    n_compared++;
    if (sym_ready !== 1'b0 || key_valid !== 1'b1 || key_data !== 8'h61) begin
      n_mismatched++;
      $display("[TB] FAIL held: rdy=%0b vld=%0b data=%02h, expected 0/1/61", sym_ready, key_valid, key_data);
    end
    key_ready = 1'b1;
    @(negedge clk48);
    while (!sym_ready && n < 50) begin
      @(negedge clk48);
      n++;
    end
    @(posedge clk48);
    #1;
    sym_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] codes [20] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                               8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C};
    int bad = 0;
    key_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(8'h61 + 8'(i));
      send_byte(codes[i]);
      if (key_valid !== 1'b1 || sym_ready !== 1'b1) bad++;
    end
    n_compared++;
    if (bad != 0) begin
      n_mismatched++;
      $display("[TB] FAIL streaming_count: %0d cycles with vld/rdy low, expected 0", bad);
    end
    wait_drain();
  endtask

  task automatic test_async_reset();
    @(posedge clk48); #1;
    key_ready = 1'b0;
    send_byte(8'h58);
    send_byte(8'h1C);
    send_byte(8'h32);
    send_byte(8'hE0);
    send_byte(8'hF0);
    n_compared++;
    if (key_valid !== 1'b1 || caps_state !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL pre_reset: vld=%0b caps=%0b, expected 1/1", key_valid, caps_state);
    end
    rst_n = 1'b0;
    #1;
    n_compared++;
    if ({sym_ready, key_valid, key_data, caps_state} !== 11'd0) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset: rdy=%0b vld=%0b data=%02h caps=%0b, expected all 0",
               sym_ready, key_valid, key_data, caps_state);
    end
    exp_q.delete();
    repeat (2) @(negedge clk48);
    rst_n = 1'b1;
    @(posedge clk48); #1;
    key_ready = 1'b1;
    send_byte(8'h75);
    exp_q.push_back(8'h61); send_byte(8'h1C);
    send_byte(8'hE0);
`ifdef KEYDEC_EXTENDED_EN
    exp_q.push_back(8'h80);
`endif
    send_byte(8'h75);
    exp_q.push_back(8'h61); send_byte(8'h1C);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_modifiers();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    repeat (3) @(posedge clk48);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/ps2_keydecode.md
Name: ps2_keydecode

Overview:
- Sits between the PS/2 physical-layer receiver and the core's keyboard input.
- Consumes raw set-2 scancode bytes over a valid/ready stream.
- Tracks prefix bytes (E0 extended, F0 break) and the shift, ctrl and caps-lock modifier state.
- Emits translated ASCII bytes through a small output FIFO on a second valid/ready stream.

Parameters:
FIFO_DEPTH, 8, output FIFO entries; power of two, minimum 2
FIFO_AW, 3, FIFO pointer width; equals log2(FIFO_DEPTH)

Ports:
clk48  input  1  system clock; all logic on its rising edge
rst_n  input  1  asynchronous active-low reset
sym_data  input  8  scancode byte from the PS/2 receiver
sym_valid  input  1  sym_data is valid
sym_ready  output  1  decoder accepts sym_data this cycle
key_data  output  8  translated ASCII byte (FIFO head)
key_valid  output  1  key_data is valid
key_ready  input  1  consumer takes key_data this cycle
caps_state  output  1  current caps-lock toggle, for an LED

Behaviour:
- Reset values: all outputs are 0 (sym_ready, key_valid, key_data, caps_state).
  - Reset also clears FIFO pointers and count, the parser state, and all modifiers.
  - Reset is asynchronous and takes effect mid-byte or mid-prefix; a partial prefix sequence is discarded.
  - sym_ready rises on the first clock edge after reset is released.
- Input handshake:
  - sym_ready = FIFO not full (registered from count).
  - A byte is consumed on any cycle where sym_valid && sym_ready.
  - Prefix and modifier bytes are also gated by !full. This is deliberate: it keeps the ordering simple.
- Parser FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen).
  - IDLE: E0 -> EXT; F0 -> BRK; other bytes are treated as a make code -> IDLE.
  - EXT: F0 -> EXT_BRK; other bytes are an extended make -> IDLE.
  - BRK: any byte is a break code -> IDLE.
  - EXT_BRK: any byte is an extended break -> IDLE.
  - E0 received while in EXT, or E0/F0 received while in BRK or EXT_BRK, is treated as the final code byte. It is unmapped, so it is dropped and the FSM returns to IDLE.
- Modifiers:
  - lshift (12) and rshift (59) are held by their own make and cleared by their own break.
  - ctrl: 14, plain or E0-prefixed, sets on make and clears on break.
  - caps: 58 make toggles caps_state; 58 break is ignored.
  - Modifier bytes never push to the FIFO.
- Translation (make codes only, non-extended; breaks never push):
  - Letters 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A -> 'a'..'z'.
    - Uppercase when shift XOR caps.
    - With ctrl held, output is the uppercase code & 0x1F (for example 1C -> 01).
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 -> '0'..'9'.
    - With shift: ')','!','@','#','$','%','^','&','*','('.
  - 4E -> '-'/'_'; 55 -> '='/'+'.
  - 29 -> 20; 5A -> 0D; 66 -> 08; 0D -> 09; 76 -> 1B.
  - Any other byte is dropped, including AA, FA, FE and EE.
- FIFO behaviour:
  - A translated byte is written on the same edge the scancode is accepted.
  - key_valid rises on the next cycle, so latency from accept to key_valid is 1 cycle.
  - key_data always shows the head entry and is stable while key_valid && !key_ready.
  - Pop occurs on key_valid && key_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - When full, sym_ready is 0 and no byte is lost.
  - Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: KEYDEC_EXTENDED_EN.
- Defined: extended makes E0 75/72/6B/74 (up/down/left/right) push 80/81/82/83. E0 6C (home) pushes 84 and E0 69 (end) pushes 85.
- Not defined: all extended makes other than ctrl are dropped. The FSM and prefix handling are identical in both builds.

Test Plan:
- Reset, then feed 1C, F0, 1C with key_ready=1 -> exactly one output 61; key_valid high for one cycle, 1 cycle after 1C is accepted.
- Feed 12, 1C, F0, 12, 1C -> outputs 41 then 61. Then feed 58, 1C -> caps_state=1, output 41. Then 12, 1C -> output 61.
- Feed 14, 21 -> output 03. Feed E0 14 break (E0, F0, 14), then 21 -> output 63.
- Hold key_ready=0 and feed 9 make codes (1C x9) -> sym_ready drops after 8 accepts and the 9th byte is held. Release key_ready -> nine 61 bytes in order with no loss.
- Push and pop together on every cycle across 20 bytes -> count stable, pointers wrap correctly, order preserved.
- Assert rst_n low after E0, F0 and mid-FIFO content -> all outputs 0 immediately, FIFO empty. The next byte 75 is dropped without the macro, and without the macro a following 1C gives 61. With KEYDEC_EXTENDED_EN, E0 75 gives 80.
